// File: rtl/trellis_encoder_if.sv
// rtl/trellis_encoder_if.sv - trellis description and encoder stream handshake interfaces
interface trellis_if #(
  parameter int STATES         = 4,
  parameter int INPUT_SYMBOLS  = 2,
  parameter int OUTPUT_SYMBOLS = 4
);
  localparam int STATE_BITS  = (STATES > 1) ? $clog2(STATES) : 1;
  localparam int OUTPUT_BITS = (OUTPUT_SYMBOLS > 1) ? $clog2(OUTPUT_SYMBOLS) : 1;

  logic [STATE_BITS-1:0]  next_state [STATES][INPUT_SYMBOLS];
  logic [OUTPUT_BITS-1:0] outputs    [STATES][INPUT_SYMBOLS];

  modport provider (output next_state, output outputs);
  modport consumer (input next_state, input outputs);
endinterface

interface trellis_encoder_if #(
  parameter int INPUT_BITS  = 1,
  parameter int OUTPUT_BITS = 2
);
  logic                   in_valid;
  logic [INPUT_BITS-1:0]  in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic [OUTPUT_BITS-1:0] out_symbol;
  logic                   out_first;
  logic                   out_last;
  logic                   out_tail;
  logic                   out_ready;
  logic                   term_error;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_symbol, out_first, out_last, out_tail, term_error
  );
  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_symbol, out_first, out_last, out_tail, term_error
  );
endinterface

// File: rtl/trellis_encoder.sv
// rtl/trellis_encoder.sv - frame-based trellis encoder with tail steps that return to state 0
// Optional BPSK float output enabled by defining TRELLIS_ENCODER_BPSK_EN.
module trellis_encoder #(
  parameter int    SYMBOLS        = 10,
  parameter int    STATES         = 4,
  parameter int    OUTPUT_SYMBOLS = 4,
  parameter int    INPUT_SYMBOLS  = 2,
  parameter int    TAIL_SYMBOLS   = (STATES > 1) ? $clog2(STATES) : 1,
  parameter int    BITS           = 16,
  parameter string PRECISION      = "HALF",
  localparam int   OUTPUT_BITS    = (OUTPUT_SYMBOLS > 1) ? $clog2(OUTPUT_SYMBOLS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  trellis_if.consumer       trellis,
  trellis_encoder_if.master bus
`ifdef TRELLIS_ENCODER_BPSK_EN
  ,
  output logic [0:OUTPUT_BITS-1][BITS-1:0] out_bpsk
`endif
);
  localparam int INPUT_BITS   = (INPUT_SYMBOLS > 1) ? $clog2(INPUT_SYMBOLS) : 1;
  localparam int STATE_BITS   = (STATES > 1) ? $clog2(STATES) : 1;
  localparam int DATA_SYMBOLS = SYMBOLS - TAIL_SYMBOLS;
  localparam int CNT_BITS     = $clog2(SYMBOLS + 1);
  localparam logic [CNT_BITS-1:0] DATA_CNT = CNT_BITS'(DATA_SYMBOLS);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(SYMBOLS);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL} fsm_t;

  fsm_t                   fsm_q, fsm_d;
  logic                   load_ok, accept, tail_step, step, frame_end;
  logic [INPUT_BITS-1:0]  tail_p, step_p;
  logic [STATE_BITS-1:0]  state_q, step_next, best_ns;
  logic [OUTPUT_BITS-1:0] step_symbol;
  logic [CNT_BITS-1:0]    count_q, count_inc;

  assign load_ok   = !bus.out_valid | bus.out_ready;
  assign count_inc = count_q + 1'b1;

  // Tail input steers toward the numerically smallest successor; ties keep the lowest p.
  always_comb begin
    tail_p  = '0;
    best_ns = trellis.next_state[state_q][0];
    for (int p = 1; p < INPUT_SYMBOLS; p++) begin
      if (trellis.next_state[state_q][p] < best_ns) begin
        best_ns = trellis.next_state[state_q][p];
        tail_p  = p[INPUT_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_q <= S_IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d        = fsm_q;
    bus.in_ready = 1'b0;
    tail_step    = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        bus.in_ready = load_ok;
        if (bus.in_valid && load_ok) fsm_d = (DATA_SYMBOLS == 1) ? S_TAIL : S_DATA;
      end
      S_DATA: begin
        bus.in_ready = load_ok;
        if (bus.in_valid && load_ok && count_inc == DATA_CNT) fsm_d = S_TAIL;
      end
      S_TAIL: begin
        tail_step = load_ok;
        if (load_ok && count_inc == LAST_CNT) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  assign accept      = bus.in_valid & bus.in_ready;
  assign step        = accept | tail_step;
  assign step_p      = tail_step ? tail_p : bus.in_data;
  assign step_next   = trellis.next_state[state_q][step_p];
  assign step_symbol = trellis.outputs[state_q][step_p];
  assign frame_end   = tail_step && (count_inc == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= '0;
      count_q        <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_symbol <= '0;
      bus.out_first  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.out_tail   <= 1'b0;
      bus.term_error <= 1'b0;
    end else if (step) begin
      bus.out_valid  <= 1'b1;
      bus.out_symbol <= step_symbol;
      bus.out_first  <= (fsm_q == S_IDLE);
      bus.out_tail   <= tail_step;
      bus.out_last   <= frame_end;
      count_q        <= (fsm_q == S_IDLE) ? CNT_BITS'(1) : count_inc;
      state_q        <= frame_end ? '0 : step_next;
      if (frame_end && step_next != '0) bus.term_error <= 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef TRELLIS_ENCODER_BPSK_EN
  localparam logic [63:0] POS_W = (PRECISION == "DOUBLE") ? 64'h3FF0_0000_0000_0000 :
                                  (PRECISION == "SINGLE") ? 64'h0000_0000_3F80_0000 :
                                                            64'h0000_0000_0000_3C00;
  localparam logic [63:0] NEG_W = (PRECISION == "DOUBLE") ? 64'hBFF0_0000_0000_0000 :
                                  (PRECISION == "SINGLE") ? 64'h0000_0000_BF80_0000 :
                                                            64'h0000_0000_0000_BC00;
  localparam logic [BITS-1:0] BPSK_POS = POS_W[BITS-1:0];
  localparam logic [BITS-1:0] BPSK_NEG = NEG_W[BITS-1:0];

  // Index 0 carries the symbol MSB so lanes line up with the decoder bit order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_bpsk <= '0;
    end else if (step) begin
      for (int i = 0; i < OUTPUT_BITS; i++)
        out_bpsk[i] <= step_symbol[OUTPUT_BITS-1-i] ? BPSK_POS : BPSK_NEG;
    end
  end
`endif
endmodule

// File: tb/tb_trellis_encoder.sv
// tb/tb_trellis_encoder.sv - directed self-checking bench for trellis_encoder with a (7,5) trellis
module tb_trellis_encoder;
  typedef struct packed {
    logic [1:0] sym;
    logic       first;
    logic       last;
    logic       tail;
  } fire_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cycle = 0;

  trellis_if #(.STATES(4), .INPUT_SYMBOLS(2), .OUTPUT_SYMBOLS(4)) tr ();
  trellis_encoder_if #(.INPUT_BITS(1), .OUTPUT_BITS(2)) bus ();
`ifdef TRELLIS_ENCODER_BPSK_EN
  logic [0:1][15:0] out_bpsk;
  logic [31:0]      bpsk_q[$];
`endif

  trellis_encoder #(
    .SYMBOLS(6), .STATES(4), .OUTPUT_SYMBOLS(4), .INPUT_SYMBOLS(2),
    .TAIL_SYMBOLS(2), .BITS(16), .PRECISION("HALF")
  ) dut (
    .clk(clk),
    .reset(reset),
    .trellis(tr),
    .bus(bus)
`ifdef TRELLIS_ENCODER_BPSK_EN
    ,
    .out_bpsk(out_bpsk)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  fire_t      fires[$];
  int         fire_cyc[$];
  logic       feed_q[$];
  int         stab_viol = 0;
  logic       stall_prev = 1'b0;
  logic [4:0] prev_out = '0;

  // Samples mid-cycle, after the feeder has driven this cycle's inputs.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && {bus.out_symbol, bus.out_first, bus.out_last, bus.out_tail} !== prev_out)
        stab_viol++;
      if (bus.out_valid && bus.out_ready) begin
        fires.push_back({bus.out_symbol, bus.out_first, bus.out_last, bus.out_tail});
        fire_cyc.push_back(cycle);
`ifdef TRELLIS_ENCODER_BPSK_EN
        bpsk_q.push_back(out_bpsk);
`endif
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_symbol, bus.out_first, bus.out_last, bus.out_tail};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input int n, input bit stall, input int n_fires,
                      output int ir_viol, output int ir_zero_tail);
    int  idx = 0;
    int  cyc = 0;
    int  base = fires.size();
    bit  acc;
    ir_viol = 0;
    ir_zero_tail = 0;
    while ((fires.size() - base) < n_fires && cyc < 300) begin
      @(negedge clk);
      bus.in_valid  = (idx < n);
      bus.in_data   = feed_q[(idx < n) ? idx : 0];
      bus.out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #1;
      if (idx < n) begin
        if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) ir_viol++;
      end else if (!bus.in_ready) begin
        ir_zero_tail++;
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) idx++;
      cyc++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("feed_done", 64'(cyc < 300), 64'd1);
  endtask

  task automatic check_frame(input string tag, input int base, input int n, input int exp_syms[$],
                             input logic [11:0] ef, input logic [11:0] et, input logic [11:0] el);
    logic [23:0] os, es;
    logic [11:0] of, ot, ol;
    os = '0; es = '0; of = '0; ot = '0; ol = '0;
    for (int i = 0; i < n; i++) begin
      os[2*i +: 2] = fires[base+i].sym;
      es[2*i +: 2] = exp_syms[i][1:0];
      of[i] = fires[base+i].first;
      ot[i] = fires[base+i].tail;
      ol[i] = fires[base+i].last;
    end
    check({tag, "_count"}, 64'(fires.size() - base), 64'(n));
    check({tag, "_syms"},  64'(os), 64'(es));
    check({tag, "_first"}, 64'(of), 64'(ef));
    check({tag, "_tail"},  64'(ot), 64'(et));
    check({tag, "_last"},  64'(ol), 64'(el));
  endtask

  task automatic load_trellis();
    for (int s = 0; s < 4; s++)
      for (int u = 0; u < 2; u++) begin
        tr.next_state[s][u] = 2'(2*u + (s >> 1));
        tr.outputs[s][u]    = 2'(2*(u ^ (s >> 1) ^ (s & 1)) + (u ^ (s & 1)));
      end
  endtask

  initial begin
    int ir_viol, ir_zero, base;
    load_trellis();
    bus.in_valid  = 1'b0;
    bus.in_data   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_flags", 64'({bus.out_first, bus.out_last, bus.out_tail}), 64'd0);
    check("rst_symbol", 64'(bus.out_symbol), 64'd0);
    check("rst_term", 64'(bus.term_error), 64'd0);
    reset = 1'b0;

    // Single frame, no backpressure
    feed_q = '{1, 0, 1, 1};
    base = fires.size();
    feed(4, 1'b0, 6, ir_viol, ir_zero);
    check_frame("single", base, 6, '{3, 2, 0, 1, 1, 3}, 12'b000001, 12'b110000, 12'b100000);
    check("single_ir", 64'(ir_viol), 64'd0);
    check("single_tail_ir_low", 64'(ir_zero), 64'd2);
    check("single_term", 64'(bus.term_error), 64'd0);
`ifdef TRELLIS_ENCODER_BPSK_EN
    check("bpsk_sym3", 64'(bpsk_q[base]), 64'({16'h3C00, 16'h3C00}));
    check("bpsk_sym2", 64'(bpsk_q[base+1]), 64'({16'h3C00, 16'hBC00}));
`endif

    // Same frame under 1,0,0,1 backpressure
    stab_viol = 0;
    base = fires.size();
    feed(4, 1'b1, 6, ir_viol, ir_zero);
    check_frame("stall", base, 6, '{3, 2, 0, 1, 1, 3}, 12'b000001, 12'b110000, 12'b100000);
    check("stall_stable", 64'(stab_viol), 64'd0);
    check("stall_ir", 64'(ir_viol), 64'd0);

    // Back-to-back frames with no bubble
    feed_q = '{1, 0, 1, 1, 0, 0, 0, 0};
    base = fires.size();
    feed(8, 1'b0, 12, ir_viol, ir_zero);
    check_frame("b2b", base, 12, '{3, 2, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0},
                12'b000001_000001, 12'b110000_110000, 12'b100000_100000);
    check("b2b_span", 64'(fire_cyc[base+11] - fire_cyc[base]), 64'd11);

    // Reset mid-frame with the third symbol held in the output register
    feed_q = '{1, 1, 0};
    feed(3, 1'b0, 2, ir_viol, ir_zero);
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    check("pre_rst_symbol", 64'(bus.out_symbol), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_symbol", 64'(bus.out_symbol), 64'd0);
    check("mid_rst_flags", 64'({bus.out_first, bus.out_last, bus.out_tail}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    feed_q = '{1, 1, 0, 0};
    base = fires.size();
    feed(4, 1'b0, 6, ir_viol, ir_zero);
    check_frame("after_rst", base, 6, '{3, 1, 1, 3, 0, 0}, 12'b000001, 12'b110000, 12'b100000);

    // Corrupted trellis: tail from state 3 passes through state 1 and cannot reach 0
    tr.next_state[1][0] = 2'd3;
    feed_q = '{1, 0, 1, 1};
    base = fires.size();
    feed(4, 1'b0, 6, ir_viol, ir_zero);
    check_frame("corrupt", base, 6, '{3, 2, 0, 1, 1, 0}, 12'b000001, 12'b110000, 12'b100000);
    check("corrupt_term", 64'(bus.term_error), 64'd1);
    repeat (3) @(negedge clk);
    check("corrupt_term_sticky", 64'(bus.term_error), 64'd1);
    reset = 1'b1;
    #1;
    check("corrupt_term_cleared", 64'(bus.term_error), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    load_trellis();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
